// File: rtl/nibble_add_seq.sv
// Multi-cycle WIDTH-bit add/sub on one SLICE_W-bit slice with a registered carry chain; NSLICE-cycle latency.
// One op in flight; response held in DONE until rsp_ready. Subtract support under `NIBBLE_ADD_SUB_EN.
module nibble_add_seq #(
   parameter int WIDTH   = 32,
   parameter int SLICE_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic             req_sub,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_sum,
   output logic             rsp_carry,
   output logic             rsp_ovf,
   output logic             busy
);

   localparam int NSLICE = WIDTH / SLICE_W;
   localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q;
   state_t             state_d;

   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic               carry_q;
   logic [IDX_W-1:0]   idx_q;

   logic               accept;
   logic               sub_sel;
   logic               last_slice;
   logic [SLICE_W-1:0] a_sl;
   logic [SLICE_W-1:0] b_sl;
   logic [SLICE_W:0]   slice_res;
   logic               ovf_next;

`ifdef NIBBLE_ADD_SUB_EN
   assign sub_sel = req_sub;
`else
   logic unused_sub;
   assign unused_sub = req_sub;
   assign sub_sel    = 1'b0;
`endif

   assign accept     = req_valid && req_ready;
   assign last_slice = (idx_q == IDX_W'(NSLICE - 1));

   assign a_sl      = a_q[idx_q*SLICE_W +: SLICE_W];
   assign b_sl      = b_q[idx_q*SLICE_W +: SLICE_W];
   assign slice_res = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE_W{1'b0}}, carry_q};

   // Only meaningful on the last slice, where slice_res[SLICE_W-1] is the result MSB.
   assign ovf_next = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                     (slice_res[SLICE_W-1] != a_q[WIDTH-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)     state_d = RUN;
         RUN:     if (last_slice) state_d = DONE;
         DONE:    if (rsp_ready)  state_d = IDLE;
         default:                 state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state_q == IDLE);
      rsp_valid = (state_q == DONE);
      busy      = (state_q == RUN) || (state_q == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q       <= '0;
         b_q       <= '0;
         carry_q   <= 1'b0;
         idx_q     <= '0;
         rsp_sum   <= '0;
         rsp_carry <= 1'b0;
         rsp_ovf   <= 1'b0;
      end else if (accept) begin
         a_q       <= req_a;
         b_q       <= sub_sel ? ~req_b : req_b;
         carry_q   <= sub_sel;
         idx_q     <= '0;
         rsp_sum   <= '0;
         rsp_carry <= 1'b0;
         rsp_ovf   <= 1'b0;
      end else if (state_q == RUN) begin
         rsp_sum[idx_q*SLICE_W +: SLICE_W] <= slice_res[SLICE_W-1:0];
         carry_q <= slice_res[SLICE_W];
         // idx parks on the last slice so it never wraps.
         if (last_slice) begin
            rsp_carry <= slice_res[SLICE_W];
            rsp_ovf   <= ovf_next;
         end else begin
            idx_q <= idx_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed bench for nibble_add_seq: WIDTH=32 main instance plus a WIDTH=8 instance, scoreboard-checked.
module tb_nibble_add_seq;

   typedef struct packed {
      logic [31:0] sum;
      logic        carry;
      logic        ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_sub, rsp_valid, rsp_ready;
   logic [31:0] req_a, req_b, rsp_sum;
   logic        rsp_carry, rsp_ovf, busy;

   logic        v8, rdy8, rspv8, rspr8, c8, o8, busy8;
   logic [7:0]  a8, b8, s8;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   nibble_add_seq #(.WIDTH(32), .SLICE_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf),
      .busy(busy)
   );

   nibble_add_seq #(.WIDTH(8), .SLICE_W(4)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(v8), .req_ready(rdy8),
      .req_a(a8), .req_b(b8), .req_sub(1'b0),
      .rsp_valid(rspv8), .rsp_ready(rspr8),
      .rsp_sum(s8), .rsp_carry(c8), .rsp_ovf(o8),
      .busy(busy8)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
      exp_t        e;
      logic        s;
      logic [31:0] bb;
      logic [32:0] r;
`ifdef NIBBLE_ADD_SUB_EN
      s = sub;
`else
      s = 1'b0 & sub;
`endif
      bb      = s ? ~b : b;
      r       = {1'b0, a} + {1'b0, bb} + {32'd0, s};
      e.sum   = r[31:0];
      e.carry = r[32];
      e.ovf   = (a[31] == bb[31]) && (r[31] != a[31]);
      return e;
   endfunction

   // Present one request at a negedge; returns at the negedge after the acceptance edge.
   task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sub);
      @(negedge clk);
      chk({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
      req_valid = 1'b1;
      req_a     = a;
      req_b     = b;
      req_sub   = sub;
      @(negedge clk);
      req_valid = 1'b0;
      req_a     = $urandom;
      req_b     = $urandom;
      req_sub   = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_rsp(input string tag);
      int   cyc;
      exp_t e;
      cyc = 0;
      while (!rsp_valid && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_latency"}, 64'(cyc), 64'd8);
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, "_sum"},   {32'd0, rsp_sum},   {32'd0, e.sum});
         chk({tag, "_carry"}, {63'd0, rsp_carry}, {63'd0, e.carry});
         chk({tag, "_ovf"},   {63'd0, rsp_ovf},   {63'd0, e.ovf});
      end
      chk({tag, "_busy"},     {63'd0, busy},      64'd1);
      chk({tag, "_rdy_done"}, {63'd0, req_ready}, 64'd0);
   endtask

   task automatic finish_rsp(input string tag);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk({tag, "_valid_after"}, {63'd0, rsp_valid}, 64'd0);
      chk({tag, "_rdy_after"},   {63'd0, req_ready}, 64'd1);
      chk({tag, "_busy_after"},  {63'd0, busy},      64'd0);
      req_valid = 1'b0;
   endtask

   task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic sub, input exp_t e);
      sb.push_back(e);
      issue(tag, a, b, sub);
      wait_rsp(tag);
      finish_rsp(tag);
   endtask

   initial begin
      exp_t        e;
      logic [31:0] ra, rb;
      logic        rs;
      int          cyc;

      rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_sub = 1'b0; rsp_ready = 1'b0;
      v8 = 1'b0; a8 = '0; b8 = '0; rspr8 = 1'b0;
      #3;
      chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
      chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("rst_sum",       {32'd0, rsp_sum},   64'd0);
      chk("rst_carry_ovf", {62'd0, rsp_carry, rsp_ovf}, 64'd0);
      chk("rst_busy",      {63'd0, busy},      64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      op("add_14_8",  32'd14,        32'd8, 1'b0, '{sum: 32'd22,        carry: 1'b0, ovf: 1'b0});
      op("add_wrap",  32'hFFFF_FFFF, 32'd1, 1'b0, '{sum: 32'd0,         carry: 1'b1, ovf: 1'b0});
      op("add_ovf",   32'h7FFF_FFFF, 32'd1, 1'b0, '{sum: 32'h8000_0000, carry: 1'b0, ovf: 1'b1});

      // Back-pressure: DONE held 5 cycles while req_valid/req_a toggle.
      sb.push_back('{sum: 32'h0000_0000, carry: 1'b1, ovf: 1'b1});
      issue("bp", 32'h8000_0000, 32'h8000_0000, 1'b0);
      wait_rsp("bp");
      for (int i = 0; i < 5; i++) begin
         req_valid = ~req_valid;
         req_a     = $urandom;
         @(negedge clk);
         chk("bp_hold_valid", {63'd0, rsp_valid}, 64'd1);
         chk("bp_hold_rdy",   {63'd0, req_ready}, 64'd0);
         chk("bp_hold_sum",   {32'd0, rsp_sum},   64'd0);
         chk("bp_hold_flags", {62'd0, rsp_carry, rsp_ovf}, 64'd3);
      end
      req_valid = 1'b1;
      finish_rsp("bp");

      // Reset mid-operation, just after slice 3 has been evaluated.
      issue("rst_mid", 32'h1234_5678, 32'h1111_1111, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstmid_sum",   {32'd0, rsp_sum},   64'd0);
      chk("rstmid_valid", {63'd0, rsp_valid}, 64'd0);
      chk("rstmid_rdy",   {63'd0, req_ready}, 64'd1);
      chk("rstmid_busy",  {63'd0, busy},      64'd0);
      chk("rstmid_flags", {62'd0, rsp_carry, rsp_ovf}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      op("after_rst", 32'd3, 32'd4, 1'b0, '{sum: 32'd7, carry: 1'b0, ovf: 1'b0});

`ifdef NIBBLE_ADD_SUB_EN
      op("sub_5_8",   32'd5,         32'd8, 1'b1, '{sum: 32'hFFFF_FFFD, carry: 1'b0, ovf: 1'b0});
      op("sub_min_1", 32'h8000_0000, 32'd1, 1'b1, '{sum: 32'h7FFF_FFFF, carry: 1'b1, ovf: 1'b1});
`else
      op("nosub_5_8", 32'd5, 32'd8, 1'b1, '{sum: 32'd13, carry: 1'b0, ovf: 1'b0});
`endif

      for (int i = 0; i < 4; i++) begin
         ra = $urandom;
         rb = $urandom;
         rs = 1'($urandom_range(0, 1));
         op("rand", ra, rb, rs, model(ra, rb, rs));
      end

      // WIDTH=8 instance: two slices, consumer always ready.
      @(negedge clk);
      rspr8 = 1'b1;
      chk("w8_rdy", {63'd0, rdy8}, 64'd1);
      v8 = 1'b1; a8 = 8'hF0; b8 = 8'h1F;
      @(negedge clk);
      v8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
      cyc = 0;
      while (!rspv8 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("w8_latency", 64'(cyc), 64'd2);
      chk("w8_sum",     {56'd0, s8}, 64'h0F);
      chk("w8_carry",   {63'd0, c8}, 64'd1);
      chk("w8_ovf",     {63'd0, o8}, 64'd0);
      @(negedge clk);
      chk("w8_idle", {62'd0, rspv8, rdy8}, 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/nibble_add_seq.md
# nibble_add_seq

Multi-cycle add sequencer that performs a WIDTH-bit addition over successive cycles on a single SLICE_W-bit adder slice, chaining the carry through a register. It sits between the execute stage and a shared narrow adder datapath, accepting one operation per valid/ready handshake and returning sum, carry-out and signed overflow through a response handshake. It targets area-constrained RISC-V builds where a full-width adder is not affordable.

## Interface
- WIDTH, 32, operand and result width; must be a multiple of SLICE_W.
- SLICE_W, 4, width of the adder slice evaluated per cycle; NSLICE = WIDTH/SLICE_W.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low; one clock domain only.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_a  in  WIDTH  operand A, sampled at acceptance.
- req_b  in  WIDTH  operand B, sampled at acceptance.
- req_sub  in  1  subtract request; used only when NIBBLE_ADD_SUB_EN is defined.
- rsp_valid  out  1  result available; high only in DONE.
- rsp_ready  in  1  consumer takes the result.
- rsp_sum  out  WIDTH  result register.
- rsp_carry  out  1  carry out of the MSB slice. For subtraction, 1 means no borrow.
- rsp_ovf  out  1  signed two's-complement overflow.
- busy  out  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: req_ready=1.
  - On req_valid && req_ready, the block captures A and B' (B' = B, or ~B when subtracting).
  - It also sets carry = sub (0 for add), idx = 0 and rsp_sum = 0, then moves to RUN.
- RUN: each cycle computes {c, s} = A[idx] + B'[idx] + carry over SLICE_W bits.
  - s is written into rsp_sum slice idx; carry <= c; idx <= idx + 1.
  - After slice NSLICE-1, rsp_carry <= c and the FSM moves to DONE.
- Overflow: rsp_ovf = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]). It is registered on the transition into DONE.
- DONE: rsp_valid=1 and all rsp_* outputs are held stable. On rsp_ready the FSM returns to IDLE.
- In IDLE and RUN:
  - rsp_valid=0.
  - rsp_ready is ignored.
  - req_valid is ignored whenever req_ready=0.
- rsp_sum shows partial results during RUN. It is valid only while rsp_valid=1.
- Input changes after acceptance have no effect on the operation in flight.
- idx counter width is clog2(NSLICE), minimum 1 bit. It never wraps past NSLICE-1.
- Reset mid-operation: the operation is discarded immediately. All state and outputs take their reset values.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_ovf=0, busy=0, carry=0, idx=0.
- Acceptance edge E0. Slices are evaluated at edges E1..E_NSLICE.
- rsp_valid rises after edge E_NSLICE: latency is NSLICE cycles (8 for WIDTH=32).
- The response handshake completes at the first edge with rsp_valid && rsp_ready. req_ready=1 from the following cycle.
- Minimum initiation interval is NSLICE+2 cycles. DONE and IDLE are never merged.
- A response is never dropped. rsp_valid stays high until it is consumed.

## Configuration
- NIBBLE_ADD_SUB_EN defined:
  - req_sub=1 at acceptance selects A - B, computed as B' = ~B with carry-in 1.
  - rsp_carry is the inverted borrow.
- NIBBLE_ADD_SUB_EN undefined:
  - req_sub is ignored; the port remains present.
  - B' = B, carry-in 0, and every operation is an add.

## Test plan
- WIDTH=32, add A=14, B=8 -> rsp_valid exactly 8 cycles after acceptance; sum=22, carry=0, ovf=0.
- Add boundary cases:
  - A=0xFFFFFFFF, B=1 -> sum=0, carry=1, ovf=0.
  - A=0x7FFFFFFF, B=1 -> sum=0x80000000, carry=0, ovf=1.
- Back-pressure: hold rsp_ready=0 for 5 cycles in DONE while toggling req_valid and req_a.
  - Required: outputs stay stable, req_ready=0 and no new request is accepted.
  - After rsp_ready=1: req_ready=1 the next cycle.
- Reset mid-operation: assert rst_n=0 at slice 3 of RUN.
  - Required: outputs immediately take reset values, without waiting for a clock edge.
  - After release: A=3, B=4 -> sum=7.
- With NIBBLE_ADD_SUB_EN:
  - 5-8 -> sum=0xFFFFFFFD, carry=0, ovf=0.
  - 0x80000000-1 -> sum=0x7FFFFFFF, carry=1, ovf=1.
- Without NIBBLE_ADD_SUB_EN: req_sub=1, 5,8 -> sum=13.
- WIDTH=8: 0xF0+0x1F -> latency 2 cycles, sum=0x0F, carry=1, ovf=0.
